// File: rtl/icache_refill_responder_if.sv
// Request, response, preload and flush signals between the ICache miss handler and the refill responder.
// The master side is the cache/preloader and the slave side is the responder.
interface icache_refill_responder_if #(
    parameter int PLEN       = 32,
    parameter int XLEN       = 32,
    parameter int LINE_WIDTH = 512
);
    logic                  req_valid;
    logic                  req_ready;
    logic [PLEN-1:0]       req_addr;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [LINE_WIDTH-1:0] rsp_data;
    logic                  rsp_err;
    logic                  wr_en;
    logic [PLEN-1:0]       wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic                  flush;

    modport master (
        output req_valid, req_addr, rsp_ready, wr_en, wr_addr, wr_data, flush,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, wr_en, wr_addr, wr_data, flush,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/icache_refill_responder.sv
// Refill responder: after a LATENCY-cycle wait, reads a line word-by-word and holds it until rsp_ready.
// One request in flight; req_ready only in IDLE. Macro ICACHE_REFILL_FLUSH_EN enables flush abort.
module icache_refill_responder #(
    parameter int              PLEN       = 32,
    parameter int              XLEN       = 32,
    parameter int              LINE_WIDTH = 512,
    parameter int              MEM_WORDS  = 4096,
    parameter logic [PLEN-1:0] MEM_BASE   = PLEN'(32'h8000_0000),
    parameter int              LATENCY    = 4
) (
    input logic                  clk_i,
    input logic                  rst_i,
    icache_refill_responder_if.slave bus
);
    localparam int N  = LINE_WIDTH / XLEN;
    localparam int AW = $clog2(MEM_WORDS);
    localparam int BW = $clog2(XLEN / 8);
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [CW-1:0] CNT_INIT  = CW'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam logic [KW-1:0] LAST_BEAT = KW'(N - 1);
    localparam logic [AW-1:0] LINE_MASK = ~AW'(N - 1);

    typedef enum logic [1:0] {IDLE, WAIT, READ, RESP} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [KW-1:0]   beat;
    logic [AW-1:0]   base_idx;
    logic            err;
    logic [XLEN-1:0] line_buf [N];
    logic [XLEN-1:0] mem [MEM_WORDS];

    logic            accept;
    logic            flush_req;
    logic            req_ready;
    logic            rsp_valid;

    logic [PLEN-1:0] req_off;
    logic [PLEN-1:0] wr_off;
    logic            req_in_range;
    logic            wr_in_range;
    logic [AW-1:0]   req_idx;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;
    logic [LINE_WIDTH-1:0] line_flat;

    // Offsets wrap for addresses below MEM_BASE, so they land above the array and fail the range test.
    assign req_off      = bus.req_addr - MEM_BASE;
    assign wr_off       = bus.wr_addr - MEM_BASE;
    assign req_in_range = (req_off[PLEN-1:AW+BW] == '0);
    assign wr_in_range  = (wr_off[PLEN-1:AW+BW] == '0);
    assign req_idx      = req_off[AW+BW-1:BW] & LINE_MASK;
    assign wr_idx       = wr_off[AW+BW-1:BW];
    assign rd_idx       = base_idx | AW'(beat);

`ifdef ICACHE_REFILL_FLUSH_EN
    logic unused_bits;
    assign flush_req   = bus.flush;
    assign unused_bits = ^{req_off[BW-1:0], wr_off[BW-1:0]};
`else
    logic unused_bits;
    assign flush_req   = 1'b0;
    assign unused_bits = ^{req_off[BW-1:0], wr_off[BW-1:0], bus.flush};
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid && !flush_req) begin
                    accept    = 1'b1;
                    state_nxt = (LATENCY > 0) ? WAIT : READ;
                end
            end
            WAIT: begin
                if (flush_req) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                if (flush_req) begin
                    state_nxt = IDLE;
                end else if (beat == LAST_BEAT) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (flush_req || bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt      <= '0;
            beat     <= '0;
            base_idx <= '0;
            err      <= 1'b0;
            for (int i = 0; i < N; i++) begin
                line_buf[i] <= '0;
            end
        end else begin
            if (accept) begin
                err      <= !req_in_range;
                base_idx <= req_idx;
                cnt      <= CNT_INIT;
                beat     <= '0;
            end
            if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            // The array is sampled before this edge's preload write lands, so a colliding write reads old data.
            if (state == READ && !flush_req) begin
                line_buf[beat] <= err ? '0 : mem[rd_idx];
                beat           <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (bus.wr_en && wr_in_range) begin
            mem[wr_idx] <= bus.wr_data;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_flat
        assign line_flat[k*XLEN +: XLEN] = line_buf[k];
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = line_flat;
    assign bus.rsp_err   = err;
endmodule

// File: tb/tb_icache_refill_responder.sv
// Directed and randomized refill traffic checked against an address-level memory model.
module tb_icache_refill_responder;
    localparam int          PLEN      = 32;
    localparam int          XLEN      = 32;
    localparam int          LW        = 512;
    localparam int          MW        = 4096;
    localparam int          LAT       = 4;
    localparam int          N         = LW / XLEN;
    localparam logic [31:0] BASE      = 32'h8000_0000;
    localparam logic [31:0] MEM_BYTES = MW * 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    icache_refill_responder_if #(.PLEN(PLEN), .XLEN(XLEN), .LINE_WIDTH(LW)) bus ();

    icache_refill_responder #(
        .PLEN(PLEN), .XLEN(XLEN), .LINE_WIDTH(LW), .MEM_WORDS(MW),
        .MEM_BASE(BASE), .LATENCY(LAT)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    always #5 clk_i = ~clk_i;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_mem [MW];
    logic [LW-1:0] got;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return off < MEM_BYTES;
    endfunction

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        bus.wr_en = 1'b0;
        if (in_range(addr)) model_mem[(addr - BASE) >> 2] = data;
    endtask

    task automatic accept(input logic [31:0] addr);
        chk("accept_ready", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        tick();
        bus.req_valid = 1'b0;
        chk("busy_after_accept", bus.req_ready, 1'b0);
    endtask

    // Word k of the line is read LAT+1+k edges after the acceptance edge; a write landing on that same
    // edge is not yet visible. Optional random writes exercise this while the refill is in flight.
    task automatic await_rsp(input logic [31:0] addr, input int hold, input bit rnd_wr,
                             input int flush_at, output logic [LW-1:0] line);
        logic [LW-1:0] exp;
        logic [LW-1:0] held;
        bit            err;
        int            base;
        int            n;
        int            e;
        int            widx;
        logic [31:0]   wdat;
        err  = !in_range(addr);
        base = err ? 0 : int'(((addr & ~32'h3F) - BASE) >> 2);
        exp  = '0;
        n    = 0;
        while (!bus.rsp_valid && n < 200) begin
            e = n + 1;
            if (!err && e >= LAT + 1 && e <= LAT + N) exp[(e-LAT-1)*32 +: 32] = model_mem[base + e - LAT - 1];
            if (rnd_wr && $urandom_range(0, 2) == 0) begin
                widx = err ? int'($urandom_range(0, MW - 1)) : base + int'($urandom_range(0, N - 1));
                wdat = $urandom;
                bus.wr_en   = 1'b1;
                bus.wr_addr = BASE + 32'(widx * 4);
                bus.wr_data = wdat;
                model_mem[widx] = wdat;
            end
            bus.flush = (n == flush_at);
            tick();
            n++;
            bus.wr_en = 1'b0;
            bus.flush = 1'b0;
        end
        chk("latency", n, LAT + N);
        chk("rsp_err", bus.rsp_err, err);
        chk("rsp_data", bus.rsp_data, exp);
        line = bus.rsp_data;
        held = bus.rsp_data;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", bus.rsp_valid, 1'b1);
            chk("hold_req_ready", bus.req_ready, 1'b0);
            chk("hold_data", bus.rsp_data, held);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("valid_after_hs", bus.rsp_valid, 1'b0);
        chk("ready_after_hs", bus.req_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] a;
        int          seen;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.flush     = 1'b0;
        rst_i         = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_err", bus.rsp_err, 1'b0);
        chk("rst_rsp_data", bus.rsp_data, '0);
        chk("rst_req_ready", bus.req_ready, 1'b1);
        rst_i = 1'b0;
        tick();

        for (int i = 0; i < MW; i++) preload(BASE + 32'(i * 4), $urandom);
        for (int i = 0; i < N; i++) preload(BASE + 32'(i * 4), 32'h1000 + 32'(i));
        // Both would alias onto real words if not dropped.
        preload(BASE + MEM_BYTES, 32'hDEAD_BEEF);
        preload(BASE - 32'd4, 32'hBAD0_0001);

        accept(BASE);
        await_rsp(BASE, 0, 1'b0, -1, got);
        chk("word0", got[31:0], 32'h1000);
        chk("word15", got[15*32 +: 32], 32'h100F);

        accept(BASE + 32'h24);
        await_rsp(BASE + 32'h24, 1, 1'b0, -1, got);
        chk("offset_word5", got[5*32 +: 32], 32'h1005);

        accept(BASE + 32'h4000);
        await_rsp(BASE + 32'h4000, 0, 1'b0, -1, got);

        accept(BASE + MEM_BYTES - 32'd64);
        await_rsp(BASE + MEM_BYTES - 32'd64, 0, 1'b0, -1, got);

        // Second request held on the bus through the 5-cycle stall; it must wait for the handshake.
        accept(BASE + 32'h80);
        bus.req_valid = 1'b1;
        bus.req_addr  = BASE + 32'h100;
        await_rsp(BASE + 32'h80, 5, 1'b0, -1, got);
        tick();
        bus.req_valid = 1'b0;
        chk("b2b_accepted", bus.req_ready, 1'b0);
        await_rsp(BASE + 32'h100, 0, 1'b0, -1, got);

        accept(BASE + 32'h200);
        await_rsp(BASE + 32'h200, 2, 1'b1, -1, got);

        accept(BASE);
        repeat (11) tick();
        rst_i = 1'b1;
        #1;
        chk("midread_rst_valid", bus.rsp_valid, 1'b0);
        chk("midread_rst_ready", bus.req_ready, 1'b1);
        chk("midread_rst_data", bus.rsp_data, '0);
        tick();
        rst_i = 1'b0;
        tick();
        accept(BASE);
        await_rsp(BASE, 0, 1'b0, -1, got);
        chk("after_rst_word7", got[7*32 +: 32], 32'h1007);

`ifdef ICACHE_REFILL_FLUSH_EN
        accept(BASE + 32'h40);
        repeat (2) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_ready", bus.req_ready, 1'b1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.rsp_valid) seen++;
        end
        chk("flush_no_rsp", seen, 0);
        bus.flush     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = BASE;
        tick();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        chk("flush_beats_req", bus.req_ready, 1'b1);
`else
        seen = 0;
        accept(BASE + 32'h40);
        await_rsp(BASE + 32'h40, 0, 1'b0, 2, got);
        chk("flush_ignored_seen", seen, 0);
`endif

        for (int t = 0; t < 24; t++) begin
            case ($urandom_range(0, 5))
                0:       a = BASE + MEM_BYTES + $urandom_range(0, 32'hFFFF);
                1:       a = $urandom_range(0, 32'h7FFF_FFFF);
                default: a = BASE + $urandom_range(0, MEM_BYTES - 1);
            endcase
            accept(a);
            await_rsp(a, int'($urandom_range(0, 3)), 1'b1, -1, got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
